mips_div_unit: RTL
==================

Name: mips_div_unit

Overview:
- Multi-cycle restoring divider for the MIPS datapath, executing DIV/DIVU and producing LO (quotient) and HI (remainder).
- Sits beside the ALU. The controller stalls the pipeline while busy is high, then captures the results when done pulses.
- Computes one quotient bit per cycle using trial subtraction. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a divide; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- src_a  input  WIDTH  dividend
- src_b  input  WIDTH  divisor
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when quotient/remainder are valid
- quotient  output  WIDTH  LO result
- remainder  output  WIDTH  HI result
- div_by_zero  output  1  set with done when src_b was 0

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: when rst_n = 0 at a clk edge, the block goes to IDLE and busy, done, quotient, remainder, div_by_zero all become 0. This applies in any state, including mid-operation; the aborted operation produces no done.
- States:
  - IDLE: waits for start.
  - CALC: runs the iterations; count goes 0..WIDTH-1.
  - FIX: sign correction and result register write.
- IDLE to CALC: on start = 1.
  - Captures |src_a| and |src_b|; magnitudes are taken only when is_signed = 1 and the MSB is set.
  - Captures the quotient sign (src_a[MSB] XOR src_b[MSB]) and the remainder sign (src_a[MSB]), both gated by is_signed.
  - Clears the partial remainder and count.
- CALC iteration, once per cycle:
  - {rem, dvd} <<= 1.
  - trial = rem - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and the new quotient LSB = 1; otherwise the LSB = 0.
  - After WIDTH iterations, go to FIX.
- FIX:
  - quotient = qsign ? -q : q.
  - remainder = rsign ? -rem : rem.
  - Pulse done = 1 and return to IDLE.
- Latency: the edge sampling start is edge 0; done is high in the cycle following edge WIDTH+1 (33 for WIDTH = 32).
- busy: high in CALC and FIX, and low in the cycle done is high. A new start may be accepted in that same done cycle.
- Divide by zero (src_b = 0 at start):
  - Skips CALC and goes straight to FIX.
  - quotient = all ones, remainder = src_a unchanged, div_by_zero = 1.
  - done follows 2 cycles after start (after edge 1). This result is a decided team behaviour, not MIPS-architectural.
- Signed overflow: 0x80000000 / -1 (i.e. src_b = 0xFFFFFFFF) gives quotient = 0x80000000, remainder = 0, with normal latency and no flag.
- start while busy: ignored; operands are not re-sampled.
- Output hold: quotient, remainder and div_by_zero hold their values until the next FIX. done is never asserted without a preceding accepted start.
- Rounding: quotient truncates toward zero; a nonzero remainder takes the sign of the dividend.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at start, if |src_a| < |src_b| (divisor nonzero), the block skips CALC. The result is quotient = 0, remainder = src_a, and done follows after edge 1, same as the divide-by-zero path.
- Undefined: every nonzero divisor takes the full WIDTH+2 cycle path; the results are identical, only latency differs.

Decomposition:
- Package mips_div_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FIX}.
  - localparam DIV_WIDTH = 32.
  - Function for conditional two's-complement negate.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, dvd MSB, divisor.
  - Outputs: next rem and quotient bit; carries the (WIDTH+1)-bit trial subtract.
- Instantiated once inside mips_div_unit, which holds the FSM, counter and registers.

Test Plan:
- DIVU 100 / 7: done after edge 33, quotient = 14, remainder = 2, div_by_zero = 0; busy high for exactly 33 cycles.
- DIV -7 / 2 (0xFFFFFFF9, 2): quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. DIVU on the same bits: quotient = 0x7FFFFFFC, remainder = 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. DIVU 0xFFFFFFFF / 1: quotient = 0xFFFFFFFF, remainder = 0.
- DIVU 5 / 0: done after edge 1, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
- Start 100 / 7, pulse start with 9 / 3 at edge 10: the second request is ignored and the result is 14 / 2. Then rst_n = 0 at edge 5 of a new op: all outputs are 0 next cycle and no done appears.
- With DIV_EARLY_OUT_EN, DIVU 3 / 10: done after edge 1, quotient = 0, remainder = 3. Without the macro: same values after edge 33.

Source files
------------

// File: rtl/mips_div_pkg.sv
// rtl/mips_div_pkg.sv - shared types and helpers for the MIPS DIV/DIVU unit
package mips_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH = 32;
   // Widest operand the negate helper supports; callers zero-extend and slice.
   localparam int MAX_WIDTH = 64;

   function automatic logic [MAX_WIDTH-1:0] cond_negate(input logic [MAX_WIDTH-1:0] v,
                                                         input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/mips_div_unit_div_step.sv
// rtl/mips_div_unit_div_step.sv - one combinational restoring-division iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor on entry, so the shifted value fits WIDTH+1 bits and the
   // top bit of the trial difference is a reliable borrow.
   assign shifted  = {rem, dvd_msb};
   assign trial    = shifted - {1'b0, divisor};
   assign q_bit    = ~trial[WIDTH];
   assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_div_unit.sv
// rtl/mips_div_unit.sv - multi-cycle restoring DIV/DIVU unit; optional DIV_EARLY_OUT_EN
module mips_div_unit
   import mips_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dsr_q;
   logic             qsign;
   logic             rsign;
   logic             dz_q;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             early;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      logic [MAX_WIDTH-1:0] t;
      t = cond_negate(MAX_WIDTH'(v), en);
      return t[WIDTH-1:0];
   endfunction

   always_comb begin
      a_neg = is_signed & src_a[WIDTH-1];
      b_neg = is_signed & src_b[WIDTH-1];
      mag_a = neg_w(src_a, a_neg);
      mag_b = neg_w(src_b, b_neg);
   end

`ifdef DIV_EARLY_OUT_EN
   assign early = (mag_a < mag_b);
`else
   assign early = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .dvd_msb  (dvd_q[WIDTH-1]),
      .divisor  (dsr_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         qsign       <= 1'b0;
         rsign       <= 1'b0;
         dz_q        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  qsign <= a_neg ^ b_neg;
                  rsign <= a_neg;
                  dsr_q <= mag_b;
                  count <= '0;
                  // Short paths park |a| in rem_q so FIX re-applies the
                  // dividend sign and hands back src_a unchanged.
                  if (src_b == '0) begin
                     dz_q  <= 1'b1;
                     rem_q <= mag_a;
                     dvd_q <= '0;
                     state <= FIX;
                  end else if (early) begin
                     dz_q  <= 1'b0;
                     rem_q <= mag_a;
                     dvd_q <= '0;
                     state <= FIX;
                  end else begin
                     dz_q  <= 1'b0;
                     rem_q <= '0;
                     dvd_q <= mag_a;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_next;
               dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
               count <= count + CW'(1);
               if (count == LAST) state <= FIX;
            end
            FIX: begin
               quotient    <= dz_q ? '1 : neg_w(dvd_q, qsign);
               remainder   <= neg_w(rem_q, rsign);
               div_by_zero <= dz_q;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
